// File: rtl/tile_pkg.sv
// Shared types and constants for the tile-map update master and its request FIFO.
package tile_pkg;

    // Serialiser states: one Avalon write per field, then a settle gap.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR_X = 3'd1,
        ST_WR_Y = 3'd2,
        ST_WR_T = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // Sprite peripheral register map.
    localparam logic [2:0] ADDR_X    = 3'h0;
    localparam logic [2:0] ADDR_Y    = 3'h1;
    localparam logic [2:0] ADDR_TYPE = 3'h2;

    // Sprite codes understood by the display peripheral.
    localparam logic [7:0] SPR_EMPTY  = 8'h00;
    localparam logic [7:0] SPR_APPLE  = 8'h01;
    localparam logic [7:0] SPR_HEAD_R = 8'h02;

    // One queued tile update.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] spr_type;
    } tile_req_t;

endpackage

// File: rtl/tile_req_fifo.sv
// Synchronous request FIFO. The head entry is presented as a look-ahead
// read port so the consumer can capture it on the same edge it pops.
module tile_req_fifo
    import tile_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  tile_req_t push_data,
    input  logic      pop,
    output tile_req_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    tile_req_t        mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tile_update_master.sv
// Avalon-MM writer for the tile-map sprite peripheral: queues (x, y, type)
// updates and serialises each one as X, Y, TYPE register writes plus a gap.
module tile_update_master
    import tile_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [7:0]  req_type,
    output logic [2:0]  avm_address,
    output logic [7:0]  avm_writedata,
    output logic        avm_write,
    output logic        avm_chipselect,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic [15:0] updates_done
);

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_nx;
    tile_req_t   push_req;
    tile_req_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic [7:0]  hold_y;
    logic [7:0]  hold_type;
    logic [3:0]  gap_cnt;
    logic [15:0] done_cnt;

    assign push_req       = {req_x, req_y, req_type};
    assign req_ready      = !fifo_full;
    assign pop            = (state == ST_IDLE) && !fifo_empty;
    assign busy           = (state != ST_IDLE) || !fifo_empty;
    assign avm_chipselect = avm_write;
    assign updates_done   = done_cnt;

    tile_req_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state: each write phase advances only when the slave is not stalling.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (!fifo_empty)      state_nx = ST_WR_X;
            ST_WR_X: if (!avm_waitrequest) state_nx = ST_WR_Y;
            ST_WR_Y: if (!avm_waitrequest) state_nx = ST_WR_T;
            ST_WR_T: if (!avm_waitrequest) state_nx = HAS_GAP ? ST_GAP : ST_IDLE;
            ST_GAP:  if (gap_cnt == GAP_LAST) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Registered Avalon outputs, completion counter and gap timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            done_cnt      <= '0;
            gap_cnt       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        avm_write     <= 1'b1;
                        avm_address   <= ADDR_X;
                        avm_writedata <= head.x;
                    end
                end
                ST_WR_X: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= ADDR_Y;
                        avm_writedata <= hold_y;
                    end
                end
                ST_WR_Y: begin
                    if (!avm_waitrequest) begin
                        avm_address   <= ADDR_TYPE;
                        avm_writedata <= hold_type;
                    end
                end
                ST_WR_T: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        gap_cnt   <= '0;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 4'd1;
                end
                default: begin
                    avm_write <= 1'b0;
                end
            endcase
        end
    end

    // Holding register for the fields written after X, captured on pop.
    always_ff @(posedge clk) begin
        if (pop) begin
            hold_y    <= head.y;
            hold_type <= head.spr_type;
        end
    end

endmodule

// File: tb/tb_tile_update_master.sv
// Bench for tile_update_master: a beat-queue model of the Avalon write stream
// checked every cycle, plus directed literal expectations per scenario.
module tb_tile_update_master;

    localparam int DEPTH = 8;
    localparam int GAP   = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [7:0]  req_x = '0, req_y = '0, req_type = '0;
    logic        waitreq = 1'b0;

    logic        req_ready, avm_write, avm_chipselect, busy;
    logic [2:0]  avm_address;
    logic [7:0]  avm_writedata;
    logic [15:0] updates_done;

    logic        ready0, write0, cs0, busy0;
    logic [2:0]  addr0;
    logic [7:0]  data0;
    logic [15:0] done0;

    tile_update_master #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_type(req_type),
        .avm_address(avm_address), .avm_writedata(avm_writedata),
        .avm_write(avm_write), .avm_chipselect(avm_chipselect),
        .avm_waitrequest(waitreq), .busy(busy), .updates_done(updates_done));

    tile_update_master #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready0),
        .req_x(req_x), .req_y(req_y), .req_type(req_type),
        .avm_address(addr0), .avm_writedata(data0),
        .avm_write(write0), .avm_chipselect(cs0),
        .avm_waitrequest(waitreq), .busy(busy0), .updates_done(done0));

    always #10 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: request queue feeding a queue of write beats
    logic [23:0] mq[$];
    logic [10:0] m_beats[$];
    logic        m_write = 0;
    logic [2:0]  m_addr = 0;
    logic [7:0]  m_data = 0;
    logic [15:0] m_done = 0;
    int          m_idle_in = 0;

    always @(posedge clk) begin
        bit acc;
        logic [23:0] r;
        if (reset) begin
            mq.delete();
            m_beats.delete();
            m_write = 0; m_addr = 0; m_data = 0; m_done = 0; m_idle_in = 0;
        end else begin
            acc = req_valid && (mq.size() < DEPTH);
            if (m_write) begin
                if (!waitreq) begin
                    if (m_beats.size() > 0) {m_addr, m_data} = m_beats.pop_front();
                    else begin
                        m_write = 0;
                        m_done = m_done + 16'd1;
                        m_idle_in = GAP;
                    end
                end
            end else if (m_idle_in > 0) begin
                m_idle_in--;
            end else if (mq.size() > 0) begin
                r = mq.pop_front();
                m_beats.push_back({3'd1, r[15:8]});
                m_beats.push_back({3'd2, r[7:0]});
                m_write = 1; m_addr = 3'd0; m_data = r[23:16];
            end
            if (acc) mq.push_back({req_x, req_y, req_type});
        end
    end

    function automatic bit m_busy();
        return m_write || (m_idle_in > 0) || (mq.size() > 0);
    endfunction

    // ---------------- per-cycle compare and transfer logging
    int         lg_cyc[$];
    logic [2:0] lg_a[$];
    logic [7:0] lg_d[$];
    int         x0_cyc[$];
    int         y_hold = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("write", avm_write, m_write);
            check("chipselect", avm_chipselect, m_write);
            check("address", avm_address, m_addr);
            check("writedata", avm_writedata, m_data);
            check("updates_done", updates_done, m_done);
            check("busy", busy, m_busy());
            check("req_ready", req_ready, mq.size() < DEPTH);
            if (avm_write && !waitreq) begin
                lg_cyc.push_back(cyc + 1);
                lg_a.push_back(avm_address);
                lg_d.push_back(avm_writedata);
            end
            if (avm_write && avm_address == 3'd1) y_hold++;
            if (write0 && !waitreq && addr0 == 3'd0) x0_cyc.push_back(cyc + 1);
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        lg_cyc.delete(); lg_a.delete(); lg_d.delete();
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] t, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        req_valid = 1; req_x = x; req_y = y; req_type = t;
        while (n < 200) begin
            if (req_ready) begin
                tick();
                acc_cyc = cyc;
                break;
            end
            tick();
            n++;
        end
        if (acc_cyc < 0) check("send_timeout", 1, 0);
        req_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_write || m_idle_in > 0 || mq.size() > 0) && n < 500) begin
            tick();
            n++;
        end
        tick();
        check("idle_timeout", n < 500, 1);
    endtask

    task automatic wait_y_phase();
        int n;
        n = 0;
        while (!(m_write && m_addr == 3'd1) && n < 100) begin
            tick();
            n++;
        end
        check("wr_y_timeout", n < 100, 1);
    endtask

    task automatic check_beat(input string name, input int i, input logic [2:0] a, input logic [7:0] d);
        if (i < lg_a.size()) begin
            check({name, "_addr"}, lg_a[i], a);
            check({name, "_data"}, lg_d[i], d);
        end else begin
            check({name, "_missing"}, lg_a.size(), i + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n_acc;
        logic [23:0] r;

        // Reset state
        tick(); tick();
        check("rst_write", avm_write, 0);
        check("rst_cs", avm_chipselect, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);
        check("rst_done", updates_done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 1);
        reset = 0;
        chk_en = 1;
        tick();

        // Single request: writes at t+2, t+3, t+4
        clear_log();
        send(8'd5, 8'd3, 8'h01, t);
        wait_idle();
        check("single_n", lg_a.size(), 3);
        check_beat("single_x", 0, 3'd0, 8'd5);
        check_beat("single_y", 1, 3'd1, 8'd3);
        check_beat("single_t", 2, 3'd2, 8'd1);
        if (lg_cyc.size() == 3) begin
            check("single_x_cyc", lg_cyc[0], t + 2);
            check("single_y_cyc", lg_cyc[1], t + 3);
            check("single_t_cyc", lg_cyc[2], t + 4);
        end
        check("single_done", updates_done, 1);
        check("single_busy", busy, 0);

        // Nine back-to-back requests emerge in order
        clear_log();
        for (int i = 0; i < 9; i++) send(8'(16 + i), 8'(32 + i), 8'(i % 3), t);
        wait_idle();
        check("b2b_n", lg_a.size(), 27);
        for (int i = 0; i < 9; i++) begin
            check_beat("b2b_x", 3 * i, 3'd0, 8'(16 + i));
            check_beat("b2b_y", 3 * i + 1, 3'd1, 8'(32 + i));
            check_beat("b2b_t", 3 * i + 2, 3'd2, 8'(i % 3));
        end
        check("b2b_done", updates_done, 10);

        // Stalled slave: FIFO fills (one entry held by the writer + DEPTH queued)
        waitreq = 1;
        n_acc = 0;
        req_valid = 1;
        for (int k = 0; k < 15; k++) begin
            req_x = 8'(8'h40 + k); req_y = 8'(8'h60 + k); req_type = 8'(k % 3);
            if (req_ready) n_acc++;
            tick();
        end
        req_valid = 0;
        check("fill_accepts", n_acc, DEPTH + 1);
        check("fill_ready", req_ready, 0);
        check("fill_write_held", avm_write, 1);
        check("fill_addr_held", avm_address, 0);
        check("fill_data_held", avm_writedata, 8'h40);
        waitreq = 0;
        wait_idle();
        check("fill_done", updates_done, 19);

        // waitrequest for 5 cycles during the Y write
        clear_log();
        send(8'd7, 8'd9, 8'h02, t);
        wait_y_phase();
        y_hold = 0;
        waitreq = 1;
        repeat (5) tick();
        waitreq = 0;
        wait_idle();
        check("stall_y_hold", y_hold, 6);
        check("stall_n", lg_a.size(), 3);
        check_beat("stall_y", 1, 3'd1, 8'd9);
        check_beat("stall_t", 2, 3'd2, 8'd2);
        if (lg_cyc.size() == 3) begin
            check("stall_x_cyc", lg_cyc[0], t + 2);
            check("stall_y_cyc", lg_cyc[1], t + 8);
            check("stall_t_cyc", lg_cyc[2], t + 9);
        end
        check("stall_done", updates_done, 20);

        // Reset during WR_Y with three requests queued
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i), 8'(8'hB0 + i), 8'h1, t);
        wait_y_phase();
        reset = 1;
        tick();
        check("midrst_write", avm_write, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", updates_done, 0);
        check("midrst_ready", req_ready, 1);
        reset = 0;
        tick();
        clear_log();
        send(8'h11, 8'h22, 8'h02, t);
        wait_idle();
        check("post_rst_n", lg_a.size(), 3);
        check_beat("post_rst_x", 0, 3'd0, 8'h11);
        check_beat("post_rst_y", 1, 3'd1, 8'h22);
        check_beat("post_rst_t", 2, 3'd2, 8'h02);
        check("post_rst_done", updates_done, 1);

        // GAP_CYCLES=0 instance: X writes exactly 4 cycles apart
        x0_cyc.delete();
        send(8'h31, 8'h32, 8'h0, t);
        send(8'h41, 8'h42, 8'h1, t);
        wait_idle();
        check("gap0_n", x0_cyc.size(), 2);
        if (x0_cyc.size() == 2) check("gap0_spacing", x0_cyc[1] - x0_cyc[0], 4);
        check("gap0_done", done0, 3);
        check("gap0_busy", busy0, 0);

        // Counter wrap from 16'hFFFF
        m_done = 16'hFFFF;
        force dut.done_cnt = 16'hFFFF;
        tick();
        release dut.done_cnt;
        tick();
        check("wrap_pre", updates_done, 16'hFFFF);
        send(8'd1, 8'd2, 8'h0, t);
        wait_idle();
        check("wrap_post", updates_done, 16'h0000);
        check("wrap_busy", busy, 0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
